// File: rtl/rca_pkg.sv
// Shared types for the shared ripple-carry adder block.
// State encoding and adder width used by the arbiter and adder.
package rca_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        RESP = 2'b10
    } state_t;

    localparam int RCA_W = 8;

endpackage

// File: rtl/rca8.sv
// 8-bit ripple-carry adder; carry-out lands in y[8].
// Purely combinational, one full-adder cell per bit.
module rca8
    import rca_pkg::*;
(
    input  logic [RCA_W-1:0] a,
    input  logic [RCA_W-1:0] b,
    output logic [RCA_W:0]   y
);

    logic [RCA_W:0] c;

    assign c[0] = 1'b0;

    for (genvar i = 0; i < RCA_W; i++) begin : g_fa
        assign y[i]   = a[i] ^ b[i] ^ c[i];
        assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
    end

    assign y[RCA_W] = c[RCA_W];

endmodule

// File: rtl/rca_share_arbiter.sv
// Round-robin sharing of one rca8 adder among NREQ requesters.
// One operation in flight; result held until the response handshake.
module rca_share_arbiter
    import rca_pkg::*;
#(
    parameter  int NREQ = 4,
    parameter  int W    = 8,
    localparam int IDW  = $clog2(NREQ)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NREQ-1:0]   req_valid,
    output logic [NREQ-1:0]   req_ready,
    input  logic [NREQ*W-1:0] req_a,
    input  logic [NREQ*W-1:0] req_b,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [IDW-1:0]    rsp_id,
    output logic [W:0]        rsp_sum
);

    state_t         state;
    logic [IDW-1:0] rr_ptr;
    logic [IDW-1:0] gnt_id;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W:0]     add_y;

    logic           found;
    logic [IDW-1:0] grant;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    int             idx;

    // Find-first valid request starting at rr_ptr, wrapping around.
    always_comb begin
        found = 1'b0;
        grant = '0;
        idx   = 0;
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < NREQ; k++) begin
            idx = (int'(rr_ptr) + k) % NREQ;
            if (!found && req_valid[idx]) begin
                found = 1'b1;
                grant = IDW'(idx);
            end
        end
        for (int i = 0; i < NREQ; i++) begin
            if (grant == IDW'(i)) begin
                sel_a = req_a[i*W +: W];
                sel_b = req_b[i*W +: W];
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && found)
            req_ready[grant] = 1'b1;
    end

    rca8 u_add (
        .a (op_a),
        .b (op_b),
        .y (add_y)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            gnt_id    <= '0;
            op_a      <= '0;
            op_b      <= '0;
            rsp_valid <= 1'b0;
            rsp_id    <= '0;
            rsp_sum   <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (found) begin
                        op_a   <= sel_a;
                        op_b   <= sel_b;
                        gnt_id <= grant;
                        state  <= CALC;
                    end
                end
                CALC: begin
                    rsp_sum   <= add_y;
                    rsp_id    <= gnt_id;
                    rsp_valid <= 1'b1;
                    state     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid <= 1'b0;
                        rr_ptr    <= (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
